eq_smpl_sched: RTL and testbench



---
 rtl/eq_smpl_sched.sv | 180 ++++++++++++++++++
 tb/tb_eq_smpl_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/eq_smpl_sched.sv
// Per-sample scheduler for the equalizer datapath: queue write strobes per codec
// sample and a single out_latch once every issued FIR pass has finished.
module eq_smpl_sched #(
  parameter int unsigned DECIM    = 2,
  parameter int unsigned START_TO = 8,
  parameter int unsigned SEQ_TO   = 1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        valid,
  input  logic        seq_lo,
  input  logic        seq_hi,
  input  logic        clr_err,
  output logic        wrt_lo,
  output logic        wrt_hi,
  output logic        out_latch,
  output logic        busy,
  output logic        overrun,
  output logic        timeout,
  output logic [15:0] smpl_cnt
);

  localparam int unsigned   TMAX       = (SEQ_TO > START_TO) ? SEQ_TO : START_TO;
  localparam int unsigned   TW         = $clog2(TMAX + 1);
  localparam logic [2:0]    PH_LAST    = 3'(DECIM - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] SEQ_LAST   = TW'(SEQ_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_LATCH      = 3'd4
  } state_e;

  state_e        state_q;
  logic          valid_q;
  logic          arm_q;
  logic          lo_issued_q;
  logic [2:0]    phase_q;
  logic [TW-1:0] timer_q;
  logic          wrt_lo_q;
  logic          wrt_hi_q;
  logic          out_latch_q;
  logic          busy_q;
  logic          overrun_q;
  logic          timeout_q;
  logic [15:0]   smpl_cnt_q;

  logic rise_s;
  logic seq_act_s;
  logic ovr_set_s;
  logic tmo_set_s;

  // arm_q keeps a level held high across reset release from looking like a new sample
  assign rise_s    = valid & ~valid_q & arm_q;
  assign seq_act_s = seq_hi | (lo_issued_q & seq_lo);
  assign ovr_set_s = rise_s & (state_q != S_IDLE);
  assign tmo_set_s = (state_q == S_WAIT_DONE) & seq_act_s & (timer_q == SEQ_LAST);

  // valid edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      arm_q   <= ~valid;
    end else begin
      valid_q <= valid;
      arm_q   <= arm_q | ~valid;
    end
  end

  // scheduler FSM with its registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 3'd0;
      lo_issued_q <= 1'b0;
      timer_q     <= '0;
      wrt_lo_q    <= 1'b0;
      wrt_hi_q    <= 1'b0;
      out_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      smpl_cnt_q  <= 16'd0;
    end else begin
      wrt_lo_q    <= 1'b0;
      wrt_hi_q    <= 1'b0;
      out_latch_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (rise_s && en) begin
            state_q <= S_WRITE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_WRITE: begin
          wrt_hi_q    <= 1'b1;
          wrt_lo_q    <= (phase_q == 3'd0);
          lo_issued_q <= (phase_q == 3'd0);
          phase_q     <= (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
          timer_q     <= '0;
          state_q     <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (seq_act_s) begin
            timer_q <= '0;
            state_q <= S_WAIT_DONE;
          end else if (timer_q == START_LAST) begin
            // no FIR pass started: the write only primed the queue
            timer_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!seq_act_s) begin
            timer_q     <= '0;
            out_latch_q <= 1'b1;
            smpl_cnt_q  <= smpl_cnt_q + 16'd1;
            state_q     <= S_LATCH;
          end else if (timer_q == SEQ_LAST) begin
            timer_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_LATCH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          timer_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // sticky error flags; a new set condition beats clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (ovr_set_s) begin
        overrun_q <= 1'b1;
      end else if (clr_err) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end
      if (tmo_set_s) begin
        timeout_q <= 1'b1;
      end else if (clr_err) begin
        timeout_q <= 1'b0;
      end else begin
        timeout_q <= timeout_q;
      end
    end
  end

  assign wrt_lo    = wrt_lo_q;
  assign wrt_hi    = wrt_hi_q;
  assign out_latch = out_latch_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;
  assign smpl_cnt  = smpl_cnt_q;

endmodule

// File: tb/tb_eq_smpl_sched.sv
// Directed, table-driven bench for eq_smpl_sched; each record is one codec sample
// with its FIR sequencing windows and the hand-computed outcome.
module tb_eq_smpl_sched;

  localparam int DECIM    = 2;
  localparam int START_TO = 24;
  localparam int SEQ_TO   = 1600;

  logic        clk = 1'b0;
  logic        rst, en, valid, seq_lo, seq_hi, clr_err;
  logic        wrt_lo, wrt_hi, out_latch, busy, overrun, timeout;
  logic [15:0] smpl_cnt;

  int n_cmp = 0;
  int n_err = 0;

  eq_smpl_sched #(.DECIM(DECIM), .START_TO(START_TO), .SEQ_TO(SEQ_TO)) dut (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .seq_lo(seq_lo), .seq_hi(seq_hi),
    .clr_err(clr_err), .wrt_lo(wrt_lo), .wrt_hi(wrt_hi), .out_latch(out_latch),
    .busy(busy), .overrun(overrun), .timeout(timeout), .smpl_cnt(smpl_cnt)
  );

  always #5 clk = ~clk;

  // windows are [s,e) in cycles after the write; en_off/ovr_k are observation indices (0 = unused)
  typedef struct {
    logic en;
    int   en_off, lo_s, lo_e, hi_s, hi_e, ovr_k, budget;
    int   x_hi, x_lo, x_lat_k, x_busy, x_cnt;
    logic x_ovr, x_tmo;
    int   x_tmo_k;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic en_v, input int en_off, lo_s, lo_e, hi_s, hi_e, ovr_k, budget,
                     x_hi, x_lo, x_lat_k, x_busy, x_cnt, input logic x_ovr, x_tmo,
                     input int x_tmo_k);
    vec_t v;
    v.en = en_v; v.en_off = en_off; v.lo_s = lo_s; v.lo_e = lo_e; v.hi_s = hi_s; v.hi_e = hi_e;
    v.ovr_k = ovr_k; v.budget = budget; v.x_hi = x_hi; v.x_lo = x_lo; v.x_lat_k = x_lat_k;
    v.x_busy = x_busy; v.x_cnt = x_cnt; v.x_ovr = x_ovr; v.x_tmo = x_tmo; v.x_tmo_k = x_tmo_k;
    vq.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   n_hi, n_lo, n_lat, lat_k, hi_k, n_busy, tmo_k;
    logic prev_tmo;
    n_hi = 0; n_lo = 0; n_lat = 0; lat_k = 0; hi_k = 0; n_busy = 0; tmo_k = 0;
    prev_tmo = timeout;
    en    = v.en;
    valid = 1'b1;
    for (int k = 1; k <= v.budget; k++) begin
      step();
      if (wrt_hi) begin
        n_hi++;
        if (hi_k == 0) hi_k = k;
      end
      if (wrt_lo) n_lo++;
      if (out_latch) begin
        n_lat++;
        if (lat_k == 0) lat_k = k;
      end
      if (busy) n_busy++;
      if (timeout && !prev_tmo && tmo_k == 0) tmo_k = k;
      prev_tmo = timeout;
      seq_lo = (k - 2 >= v.lo_s) && (k - 2 < v.lo_e);
      seq_hi = (k - 2 >= v.hi_s) && (k - 2 < v.hi_e);
      if (v.ovr_k != 0 && k == v.ovr_k)     valid = 1'b0;
      if (v.ovr_k != 0 && k == v.ovr_k + 1) valid = 1'b1;
      if (v.en_off != 0 && k == v.en_off)   en = 1'b0;
    end
    seq_lo = 1'b0;
    seq_hi = 1'b0;
    valid  = 1'b0;
    step();
    step();
    chk($sformatf("v%0d wrt_hi count", idx), n_hi, v.x_hi);
    chk($sformatf("v%0d wrt_hi cycle", idx), hi_k, (v.x_hi != 0) ? 2 : 0);
    chk($sformatf("v%0d wrt_lo count", idx), n_lo, v.x_lo);
    chk($sformatf("v%0d out_latch count", idx), n_lat, (v.x_lat_k != 0) ? 1 : 0);
    chk($sformatf("v%0d out_latch cycle", idx), lat_k, v.x_lat_k);
    chk($sformatf("v%0d busy cycles", idx), n_busy, v.x_busy);
    chk($sformatf("v%0d smpl_cnt", idx), int'(smpl_cnt), v.x_cnt);
    chk($sformatf("v%0d overrun", idx), int'(overrun), int'(v.x_ovr));
    chk($sformatf("v%0d timeout", idx), int'(timeout), int'(v.x_tmo));
    chk($sformatf("v%0d timeout cycle", idx), tmo_k, v.x_tmo_k);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    int n_act;
    rst = 1'b1; en = 1'b0; valid = 1'b0; seq_lo = 1'b0; seq_hi = 1'b0; clr_err = 1'b0;
    repeat (3) step();
    chk("reset flags", int'({wrt_lo, wrt_hi, out_latch, busy, overrun, timeout}), 0);
    chk("reset smpl_cnt", int'(smpl_cnt), 0);
    rst = 1'b0;
    repeat (4) step();

    //  en off  lo_s lo_e  hi_s hi_e  ovr  budget  hi lo lat_k busy cnt  ovr   tmo   tmo_k
    add(1'b1, 0,  0,   0,    20, 1040, 0,   2000,  1, 1, 1043, 1043, 1,  1'b0, 1'b0, 0);    // v0
    add(1'b1, 0,  0,   0,    20, 1040, 0,   2000,  1, 0, 1043, 1043, 2,  1'b0, 1'b0, 0);    // v1
    add(1'b1, 0,  0,   0,    20, 1040, 0,   2000,  1, 1, 1043, 1043, 3,  1'b0, 1'b0, 0);    // v2
    add(1'b1, 0,  0,   0,    20, 1040, 0,   2000,  1, 0, 1043, 1043, 4,  1'b0, 1'b0, 0);    // v3
    add(1'b1, 0,  0,   0,    0,  0,    0,   60,    1, 1, 0,    25,   4,  1'b0, 1'b0, 0);    // v4 priming
    add(1'b0, 0,  0,   0,    5,  30,   0,   60,    0, 0, 0,    0,    4,  1'b0, 1'b0, 0);    // v5 en low
    add(1'b1, 0,  0,   0,    20, 1040, 500, 1100,  1, 0, 1043, 1043, 5,  1'b1, 1'b0, 0);    // v6 overrun
    add(1'b1, 0,  0,   0,    0,  5000, 0,   1700,  1, 1, 0,    1602, 5,  1'b0, 1'b1, 1603); // v7 timeout
    add(1'b1, 0,  0,   0,    20, 100,  0,   200,   1, 0, 103,  103,  6,  1'b0, 1'b1, 0);    // v8
    add(1'b1, 0,  10,  1030, 15, 1535, 0,   1600,  1, 1, 1538, 1538, 7,  1'b0, 1'b0, 0);    // v9 stagger
    add(1'b1, 0,  5,   300,  10, 50,   0,   400,   1, 0, 53,   53,   8,  1'b0, 1'b0, 0);    // v10 lo ignored
    add(1'b1, 0,  0,   0,    5,  40,   42,  80,    1, 1, 43,   43,   9,  1'b1, 1'b0, 0);    // v11 rise at LATCH
    add(1'b1, 10, 0,   0,    5,  40,   0,   80,    1, 0, 43,   43,   10, 1'b0, 1'b0, 0);    // v12 en drop
    add(1'b0, 0,  0,   0,    5,  40,   0,   80,    0, 0, 0,    0,    10, 1'b0, 1'b0, 0);    // v13 ignored

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(i, vq[i]);
      if (i == 6) begin
        clear_errs();
        chk("clr overrun", int'(overrun), 0);
      end
      if (i == 8) begin
        clear_errs();
        chk("clr timeout", int'(timeout), 0);
      end
      if (i == 11) begin
        clear_errs();
        chk("clr overrun late", int'(overrun), 0);
      end
    end

    // pass interrupted by reset in WAIT_DONE; also set-beats-clear on overrun
    en = 1'b1;
    valid = 1'b1;
    step();
    step();
    chk("pre-reset wrt_hi", int'(wrt_hi), 1);
    chk("pre-reset wrt_lo", int'(wrt_lo), 1);
    seq_hi = 1'b1;
    repeat (5) step();
    chk("pre-reset busy", int'(busy), 1);
    valid = 1'b0;
    step();
    valid = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("set beats clr", int'(overrun), 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mid reset flags", int'({wrt_lo, wrt_hi, out_latch, busy, overrun, timeout}), 0);
    chk("mid reset smpl_cnt", int'(smpl_cnt), 0);
    rst = 1'b0;
    seq_hi = 1'b0;
    n_act = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (wrt_hi || busy || out_latch) n_act++;
    end
    chk("held valid no rise", n_act, 0);
    valid = 1'b0;
    step();
    valid = 1'b1;
    step();
    step();
    chk("post-reset wrt_hi", int'(wrt_hi), 1);
    chk("post-reset phase0", int'(wrt_lo), 1);
    repeat (40) step();
    chk("post-reset idle", int'(busy), 0);
    chk("post-reset smpl_cnt", int'(smpl_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
